// File: rtl/simplez_sequencer.sv
// Simplez CPU control unit: four-phase sequencer (I0, I1, O0, O1) plus HALT that drives
// the datapath microorders, with optional wait-state stretching of the memory phases.
module simplez_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] opcode,
  input  logic       z,
  output logic       lec,
  output logic       esc,
  output logic       era,
  output logic       incp,
  output logic       ecp,
  output logic       ccp,
  output logic       scp,
  output logic       eri,
  output logic       sri,
  output logic       eac,
  output logic       sac,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       stop
);

  // O0 is split by operation so the opcode can change freely once I1 has passed.
  typedef enum logic [2:0] {
    S_I0     = 3'd0,
    S_I1     = 3'd1,
    S_O0_ST  = 3'd2,
    S_O1     = 3'd3,
    S_HALT   = 3'd4,
    S_O0_LD  = 3'd5,
    S_O0_ADD = 3'd6
  } state_t;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_DEC  = 2'b10;
  localparam logic [1:0] ALU_CLR  = 2'b11;

  localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_I0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_I0: begin
          if (w_last) begin
            r_state <= S_I1;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_I1: begin
          r_cnt <= 4'd0;
          case (opcode)
            OP_ST:   r_state <= S_O0_ST;
            OP_LD:   r_state <= S_O0_LD;
            OP_ADD:  r_state <= S_O0_ADD;
            OP_HALT: r_state <= S_HALT;
            default: r_state <= S_I0;
          endcase
        end
        S_O0_ST, S_O0_LD, S_O0_ADD: begin
          if (w_last) begin
            r_state <= S_O1;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_O1: begin
          r_state <= S_I0;
          r_cnt   <= 4'd0;
        end
        S_HALT: begin
          r_state <= S_HALT;
          r_cnt   <= 4'd0;
        end
        default: begin
          r_state <= S_I0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Write/load strobes fire only on the final cycle of a stretched phase.
  always_comb begin
    lec    = 1'b0;
    esc    = 1'b0;
    era    = 1'b0;
    incp   = 1'b0;
    ecp    = 1'b0;
    ccp    = 1'b0;
    scp    = 1'b0;
    eri    = 1'b0;
    sri    = 1'b0;
    eac    = 1'b0;
    sac    = 1'b0;
    alu_op = ALU_PASS;
    stop   = 1'b0;
    if (rstn) begin
      case (r_state)
        S_I0: begin
          lec = 1'b1;
          if (w_last) begin
            eri  = 1'b1;
            incp = 1'b1;
          end
        end
        S_I1: begin
          case (opcode)
            OP_ST, OP_LD, OP_ADD: begin
              sri = 1'b1;
              era = 1'b1;
            end
            OP_BR: begin
              sri = 1'b1;
              ccp = 1'b1;
              era = 1'b1;
            end
            OP_BZ: begin
              era = 1'b1;
              if (z) begin
                sri = 1'b1;
                ccp = 1'b1;
              end else begin
                scp = 1'b1;
              end
            end
            OP_CLR: begin
              eac    = 1'b1;
              alu_op = ALU_CLR;
              scp    = 1'b1;
              era    = 1'b1;
            end
            OP_DEC: begin
              eac    = 1'b1;
              alu_op = ALU_DEC;
              scp    = 1'b1;
              era    = 1'b1;
            end
            default: ;
          endcase
        end
        S_O0_LD: begin
          lec = 1'b1;
          eac = w_last;
        end
        S_O0_ADD: begin
          lec = 1'b1;
          if (w_last) begin
            eac    = 1'b1;
            alu_op = ALU_ADD;
          end
        end
        S_O0_ST: begin
          sac = 1'b1;
          esc = w_last;
        end
        S_O1: begin
          scp = 1'b1;
          era = 1'b1;
        end
        S_HALT: stop = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      S_O0_ST, S_O0_LD, S_O0_ADD: state = 3'd2;
      default:                    state = r_state;
    endcase
  end

endmodule
